// File: rtl/q_sweep_pkg.sv
// Shared types, status encoding and width helper for the Q setpoint sweep sequencer.
package q_sweep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInitRst,
    StTrack,
    StSettle,
    StStepRst,
    StAbortRst
  } sweep_state_e;

  localparam logic ST_CONVERGED = 1'b0;
  localparam logic ST_TIMEOUT   = 1'b1;

  // Bits for a counter running 0..count-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count <= 32'd2) ? 32'd1 : $clog2(count);
  endfunction

endpackage

// File: rtl/q_sweep_table.sv
// Setpoint register file: one write port, one combinational read port, cleared on reset.
module q_sweep_table
  import q_sweep_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 10,
  parameter int unsigned N_POINTS  = 6,
  parameter int unsigned IDX_W     = $clog2(N_POINTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_addr,
  input  logic [BUS_WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0]     i_rd_addr,
  output logic [BUS_WIDTH-1:0] o_rd_data
);

  localparam int unsigned AW = IDX_W + 1;

  logic [BUS_WIDTH-1:0] r_mem [N_POINTS];
  logic                 w_addr_ok;

  // Addresses past the last entry are silently dropped.
  assign w_addr_ok = ({1'b0, i_wr_addr} < AW'(N_POINTS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(N_POINTS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && w_addr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/q_sweep_sequencer.sv
// Q setpoint sweep sequencer: steps q_desired through a table, waiting for convergence per point.
// Optional Q_SWEEP_LATENCY_EN adds o_status_cycles (TRACK cycle count reported with each status).
module q_sweep_sequencer
  import q_sweep_pkg::*;
#(
  parameter int unsigned BUS_WIDTH        = 10,
  parameter int unsigned N_POINTS         = 6,
  parameter int unsigned TIMEOUT_CYCLES   = 500000,
  parameter int unsigned SETTLE_CYCLES    = 75,
  parameter int unsigned RST_PULSE_CYCLES = 75,
  parameter int unsigned IDX_W            = $clog2(N_POINTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_addr,
  input  logic [BUS_WIDTH-1:0] i_wr_data,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_loop_mode,
  input  logic                 i_converged,
  output logic [BUS_WIDTH-1:0] o_q_desired,
  output logic                 o_loop_rst,
  output logic                 o_loop_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_status_valid,
  output logic [IDX_W-1:0]     o_status_idx,
  output logic                 o_status_timeout,
  output logic                 o_wr_err
`ifdef Q_SWEEP_LATENCY_EN
  ,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] o_status_cycles
`endif
);

  localparam int unsigned RST_W = cnt_width(RST_PULSE_CYCLES);
  localparam int unsigned SET_W = cnt_width(SETTLE_CYCLES);
  localparam int unsigned TRK_W = cnt_width(TIMEOUT_CYCLES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

  sweep_state_e         r_state, w_state_nxt;
  logic [RST_W-1:0]     r_rst_cnt, w_rst_cnt_nxt;
  logic [SET_W-1:0]     r_set_cnt, w_set_cnt_nxt;
  logic [TRK_W-1:0]     r_trk_cnt, w_trk_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [BUS_WIDTH-1:0] r_q_desired;
  logic [BUS_WIDTH-1:0] w_rd_data;
  logic                 w_load_q;
  logic                 r_status_valid, w_sv_nxt;
  logic [IDX_W-1:0]     r_status_idx;
  logic                 r_status_timeout, w_sv_timeout;
  logic                 r_done, w_done_nxt;
  logic                 r_wr_err, w_wr_err_nxt;
  logic                 w_busy;
  logic                 w_tbl_we;

  assign w_busy   = (r_state != StIdle);
  assign w_tbl_we = i_wr_en && !w_busy;

  // Read port follows the next index so q_desired can be loaded on the TRACK entry edge.
  q_sweep_table #(
    .BUS_WIDTH (BUS_WIDTH),
    .N_POINTS  (N_POINTS),
    .IDX_W     (IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_tbl_we),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (w_idx_nxt),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = '0;
    w_set_cnt_nxt = '0;
    w_trk_cnt_nxt = '0;
    w_idx_nxt     = r_idx;
    w_load_q      = 1'b0;
    w_sv_nxt      = 1'b0;
    w_sv_timeout  = ST_CONVERGED;
    w_done_nxt    = 1'b0;
    w_wr_err_nxt  = r_wr_err | (i_wr_en & w_busy);

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt  = StInitRst;
          w_idx_nxt    = '0;
          w_wr_err_nxt = 1'b0;
        end
      end
      StInitRst: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = StTrack;
          w_load_q    = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
      end
      StTrack: begin
        if (i_converged) begin
          w_state_nxt  = StSettle;
          w_sv_nxt     = 1'b1;
          w_sv_timeout = ST_CONVERGED;
        end else if (r_trk_cnt == TRK_LAST) begin
          w_state_nxt  = StSettle;
          w_sv_nxt     = 1'b1;
          w_sv_timeout = ST_TIMEOUT;
        end else begin
          w_trk_cnt_nxt = r_trk_cnt + 1'b1;
        end
      end
      StSettle: begin
        if (r_set_cnt == SET_LAST) begin
          w_state_nxt = StStepRst;
        end else begin
          w_set_cnt_nxt = r_set_cnt + 1'b1;
        end
      end
      StStepRst: begin
        if (r_rst_cnt == RST_LAST) begin
          if (r_idx < IDX_LAST) begin
            w_state_nxt = StTrack;
            w_idx_nxt   = r_idx + 1'b1;
            w_load_q    = 1'b1;
          end else if (i_loop_mode) begin
            w_state_nxt = StTrack;
            w_idx_nxt   = '0;
            w_load_q    = 1'b1;
          end else begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
      end
      StAbortRst: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = StIdle;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Abort wins over every pending transition, including a same-cycle status report.
    if (i_abort && (r_state != StIdle) && (r_state != StAbortRst)) begin
      w_state_nxt   = StAbortRst;
      w_rst_cnt_nxt = '0;
      w_set_cnt_nxt = '0;
      w_trk_cnt_nxt = '0;
      w_idx_nxt     = r_idx;
      w_load_q      = 1'b0;
      w_sv_nxt      = 1'b0;
      w_done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_cnt        <= '0;
      r_set_cnt        <= '0;
      r_trk_cnt        <= '0;
      r_idx            <= '0;
      r_q_desired      <= '0;
      r_status_valid   <= 1'b0;
      r_status_idx     <= '0;
      r_status_timeout <= 1'b0;
      r_done           <= 1'b0;
      r_wr_err         <= 1'b0;
    end else begin
      r_rst_cnt      <= w_rst_cnt_nxt;
      r_set_cnt      <= w_set_cnt_nxt;
      r_trk_cnt      <= w_trk_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_status_valid <= w_sv_nxt;
      r_done         <= w_done_nxt;
      r_wr_err       <= w_wr_err_nxt;
      if (w_load_q) begin
        r_q_desired <= w_rd_data;
      end
      if (w_sv_nxt) begin
        r_status_idx     <= r_idx;
        r_status_timeout <= w_sv_timeout;
      end
    end
  end

`ifdef Q_SWEEP_LATENCY_EN
  localparam int unsigned LAT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [LAT_W-1:0] r_status_cycles;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_status_cycles <= '0;
    end else if (w_sv_nxt) begin
      r_status_cycles <= LAT_W'(r_trk_cnt);
    end
  end

  assign o_status_cycles = r_status_cycles;
`endif

  assign o_q_desired      = r_q_desired;
  assign o_loop_rst       = (r_state == StInitRst) || (r_state == StStepRst) ||
                            (r_state == StAbortRst);
  assign o_loop_start     = (r_state == StTrack) || (r_state == StSettle);
  assign o_busy           = w_busy;
  assign o_done           = r_done;
  assign o_status_valid   = r_status_valid;
  assign o_status_idx     = r_status_idx;
  assign o_status_timeout = r_status_timeout;
  assign o_wr_err         = r_wr_err;

endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Self-checking bench for q_sweep_sequencer against a cycle-timeline model of each sweep.
module tb_q_sweep_sequencer;

  localparam int BW    = 10;
  localparam int NP    = 3;
  localparam int TO    = 100;
  localparam int SC    = 5;
  localparam int RP    = 4;
  localparam int IW    = 2;
  localparam int NEVER = 10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  logic          start;
  logic          abort;
  logic          loop_mode;
  logic          converged;
  logic [BW-1:0] q_desired;
  logic          loop_rst;
  logic          loop_start;
  logic          busy;
  logic          done;
  logic          status_valid;
  logic [IW-1:0] status_idx;
  logic          status_timeout;
  logic          wr_err;
`ifdef Q_SWEEP_LATENCY_EN
  logic [$clog2(TO+1)-1:0] status_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Sweep scenario configuration consumed by run_sweep.
  int tbl[NP];
  int conv_k[6];
  int n_pts;
  int abort_pt;
  int abort_off;
  int wr_pt;
  int wr_off;
  int exp_q_hold;

  q_sweep_sequencer #(
    .BUS_WIDTH        (BW),
    .N_POINTS         (NP),
    .TIMEOUT_CYCLES   (TO),
    .SETTLE_CYCLES    (SC),
    .RST_PULSE_CYCLES (RP),
    .IDX_W            (IW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_wr_en          (wr_en),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .i_start          (start),
    .i_abort          (abort),
    .i_loop_mode      (loop_mode),
    .i_converged      (converged),
    .o_q_desired      (q_desired),
    .o_loop_rst       (loop_rst),
    .o_loop_start     (loop_start),
    .o_busy           (busy),
    .o_done           (done),
    .o_status_valid   (status_valid),
    .o_status_idx     (status_idx),
    .o_status_timeout (status_timeout),
    .o_wr_err         (wr_err)
`ifdef Q_SWEEP_LATENCY_EN
    ,
    .o_status_cycles  (status_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_defaults();
    n_pts    = NP;
    abort_pt = -1;
    abort_off = 0;
    wr_pt    = -1;
    wr_off   = 0;
    for (int j = 0; j < 6; j++) conv_k[j] = NEVER;
  endtask

  task automatic write_entry(input int addr, input int data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = IW'(addr);
    wr_data = BW'(data);
    if (addr < NP) tbl[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Cycle 0 carries start; cycle c is the cycle after clock edge c.
  task automatic run_sweep(input string tag);
    int entry[6];
    int svc[6];
    int done_c, busy_end, end_c, abort_c, wr_c;
    bit live, e_sv, e_to, e_done, e_busy, e_lrst, e_lstart, e_werr;
    int e_idx, e_q;
    entry[0] = 1 + RP;
    for (int j = 0; j < n_pts; j++) begin
      svc[j] = entry[j] + ((conv_k[j] < TO) ? conv_k[j] + 1 : TO);
      if (j + 1 < n_pts) entry[j+1] = svc[j] + SC + RP;
    end
    done_c   = svc[n_pts-1] + SC + RP;
    abort_c  = (abort_pt >= 0) ? svc[abort_pt] + abort_off : -1;
    wr_c     = (wr_pt >= 0) ? entry[wr_pt] + wr_off : -1;
    busy_end = (abort_c >= 0) ? abort_c + RP + 1 : done_c;
    end_c    = busy_end + 3;
    e_q      = exp_q_hold;

    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      start    = 1'b0;
      live     = (abort_c < 0) || (c <= abort_c);
      e_sv     = 1'b0;
      e_to     = 1'b0;
      e_idx    = 0;
      e_lstart = 1'b0;
      e_lrst   = live ? (c <= RP) : (c <= abort_c + RP);
      e_q      = exp_q_hold;
      for (int j = 0; j < n_pts; j++) begin
        if (live && c == svc[j]) begin
          e_sv  = 1'b1;
          e_idx = j % NP;
          e_to  = (conv_k[j] >= TO);
        end
        if (live && c >= entry[j] && c < svc[j] + SC) e_lstart = 1'b1;
        if (live && c >= svc[j] + SC && c < svc[j] + SC + RP) e_lrst = 1'b1;
        if (c >= entry[j] && (abort_c < 0 || entry[j] <= abort_c)) e_q = tbl[j % NP];
      end
      e_busy = (c < busy_end);
      e_done = (abort_c < 0) && (c == done_c);
      e_werr = (wr_c >= 0) && (c > wr_c);

      n_checks++;
      if (status_valid !== e_sv)
        $display("FAIL %s c=%0d status_valid got=%0b exp=%0b", tag, c, status_valid, e_sv);
      else n_pass++;
      if (e_sv && status_valid === 1'b1) begin
        n_checks++;
        if (status_idx !== IW'(e_idx))
          $display("FAIL %s c=%0d status_idx got=%0d exp=%0d", tag, c, status_idx, e_idx);
        else n_pass++;
        n_checks++;
        if (status_timeout !== e_to)
          $display("FAIL %s c=%0d status_timeout got=%0b exp=%0b", tag, c, status_timeout, e_to);
        else n_pass++;
      end
      n_checks++;
      if (done !== e_done) $display("FAIL %s c=%0d done got=%0b exp=%0b", tag, c, done, e_done);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL %s c=%0d busy got=%0b exp=%0b", tag, c, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (loop_rst !== e_lrst)
        $display("FAIL %s c=%0d loop_rst got=%0b exp=%0b", tag, c, loop_rst, e_lrst);
      else n_pass++;
      n_checks++;
      if (loop_start !== e_lstart)
        $display("FAIL %s c=%0d loop_start got=%0b exp=%0b", tag, c, loop_start, e_lstart);
      else n_pass++;
      n_checks++;
      if (q_desired !== BW'(e_q))
        $display("FAIL %s c=%0d q_desired got=%0d exp=%0d", tag, c, q_desired, e_q);
      else n_pass++;
      n_checks++;
      if (wr_err !== e_werr) $display("FAIL %s c=%0d wr_err got=%0b exp=%0b", tag, c, wr_err, e_werr);
      else n_pass++;

      converged = 1'b0;
      for (int j = 0; j < n_pts; j++) begin
        if (c == entry[j] + conv_k[j]) converged = 1'b1;
      end
      abort     = (c == abort_c);
      loop_mode = (n_pts > NP) && (c <= entry[n_pts-1]);
      wr_en     = (c == wr_c);
      wr_addr   = '0;
      wr_data   = BW'($urandom);
    end
    converged  = 1'b0;
    abort      = 1'b0;
    loop_mode  = 1'b0;
    wr_en      = 1'b0;
    exp_q_hold = e_q;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (q_desired !== '0) $display("FAIL reset q_desired got=%0d exp=0", q_desired);
    else n_pass++;
    n_checks++; if (loop_rst !== 1'b0) $display("FAIL reset loop_rst got=%0b exp=0", loop_rst);
    else n_pass++;
    n_checks++; if (loop_start !== 1'b0) $display("FAIL reset loop_start got=%0b exp=0", loop_start);
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy got=%0b exp=0", busy);
    else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset done got=%0b exp=0", done);
    else n_pass++;
    n_checks++; if (status_valid !== 1'b0) $display("FAIL reset status_valid got=%0b exp=0", status_valid);
    else n_pass++;
    n_checks++; if (status_idx !== '0) $display("FAIL reset status_idx got=%0d exp=0", status_idx);
    else n_pass++;
    n_checks++; if (status_timeout !== 1'b0) $display("FAIL reset status_timeout got=%0b exp=0", status_timeout);
    else n_pass++;
    n_checks++; if (wr_err !== 1'b0) $display("FAIL reset wr_err got=%0b exp=0", wr_err);
    else n_pass++;
    for (int i = 0; i < NP; i++) tbl[i] = 0;
    exp_q_hold = 0;
  endtask

  task automatic test_converge_sweep();
    write_entry(0, 40);
    write_entry(1, 60);
    write_entry(2, 80);
    set_defaults();
    for (int j = 0; j < NP; j++) conv_k[j] = 10;
    run_sweep("converge");
  endtask

  task automatic test_timeout();
    set_defaults();
    run_sweep("timeout");
  endtask

  task automatic test_coincide();
    set_defaults();
    conv_k[0] = 5;
    conv_k[1] = TO - 1;
    conv_k[2] = 7;
    run_sweep("coincide");
  endtask

  task automatic test_wr_err();
    set_defaults();
    for (int j = 0; j < NP; j++) conv_k[j] = 3 + j;
    wr_pt  = 0;
    wr_off = 2;
    run_sweep("wr_busy");
  endtask

  task automatic test_loop_mode();
    set_defaults();
    n_pts = 2 * NP;
    for (int j = 0; j < n_pts; j++) conv_k[j] = int'($urandom_range(0, 20));
    run_sweep("loop_mode");
  endtask

  task automatic test_abort();
    set_defaults();
    for (int j = 0; j < NP; j++) conv_k[j] = 8;
    abort_pt  = 1;
    abort_off = 2;
    run_sweep("abort_settle");
  endtask

  task automatic test_random_sweeps();
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < NP; a++) write_entry(a, int'($urandom_range(0, 1023)));
      write_entry(3, int'($urandom_range(0, 1023)));
      set_defaults();
      for (int j = 0; j < NP; j++) conv_k[j] = int'($urandom_range(0, TO + 3));
      run_sweep("random");
    end
  endtask

  task automatic test_async_reset();
    write_entry(0, 123);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RP + 1) @(negedge clk);
    n_checks++; if (loop_start !== 1'b1) $display("FAIL arst_pre loop_start got=%0b exp=1", loop_start);
    else n_pass++;
    n_checks++; if (q_desired !== BW'(tbl[0]))
      $display("FAIL arst_pre q_desired got=%0d exp=%0d", q_desired, tbl[0]);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (q_desired !== '0) $display("FAIL arst q_desired got=%0d exp=0", q_desired);
    else n_pass++;
    n_checks++; if (loop_rst !== 1'b0) $display("FAIL arst loop_rst got=%0b exp=0", loop_rst);
    else n_pass++;
    n_checks++; if (loop_start !== 1'b0) $display("FAIL arst loop_start got=%0b exp=0", loop_start);
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL arst busy got=%0b exp=0", busy);
    else n_pass++;
    n_checks++; if (status_valid !== 1'b0) $display("FAIL arst status_valid got=%0b exp=0", status_valid);
    else n_pass++;
    n_checks++; if (status_idx !== '0) $display("FAIL arst status_idx got=%0d exp=0", status_idx);
    else n_pass++;
    n_checks++; if (status_timeout !== 1'b0) $display("FAIL arst status_timeout got=%0b exp=0", status_timeout);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NP; i++) tbl[i] = 0;
    exp_q_hold = 0;
    set_defaults();
    for (int j = 0; j < NP; j++) conv_k[j] = 2 + j;
    run_sweep("post_arst");
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    abort     = 1'b0;
    loop_mode = 1'b0;
    converged = 1'b0;
    set_defaults();
    test_reset();
    test_converge_sweep();
    test_timeout();
    test_coincide();
    test_wr_err();
    test_loop_mode();
    test_abort();
    test_random_sweeps();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
